// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order word fetches, tracks outstanding request PCs,
// buffers returned instructions toward decode, and squashes in-flight work on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      pc_q;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W:0]   inflight;

  logic [31:0]      addr_fifo [DEPTH];
  logic [PTR_W-1:0] af_wr_q;
  logic [PTR_W-1:0] af_rd_q;

  logic [31:0]      buf_pc    [DEPTH];
  logic [31:0]      buf_instr [DEPTH];
  logic [PTR_W-1:0] bf_wr_q;
  logic [PTR_W-1:0] bf_rd_q;

  logic fire;
  logic retire;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Requests are throttled so every outstanding fetch already owns a buffer slot.
  assign inflight       = {1'b0, outstanding_q} + {1'b0, occ_q};
  assign imem_req_valid = reset && !redirect_valid && (inflight < (CNT_W + 1)'(DEPTH));
  assign imem_addr      = pc_q;

  assign fire   = imem_req_valid && imem_req_ready;
  assign retire = reset && imem_rsp_valid && (outstanding_q != '0);
  assign push   = retire && !redirect_valid && (drop_q == '0);
  assign pop    = reset && (occ_q != '0) && if_ready && !redirect_valid;

  assign if_valid    = reset && (occ_q != '0);
  assign if_pc       = reset ? buf_pc[bf_rd_q] : '0;
  assign if_pc_plus4 = reset ? buf_pc[bf_rd_q] + 32'd4 : '0;
  assign if_instr    = reset ? buf_instr[bf_rd_q] : '0;

  // Control state: PC, counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      occ_q         <= '0;
      af_wr_q       <= '0;
      af_rd_q       <= '0;
      bf_wr_q       <= '0;
      bf_rd_q       <= '0;
    end else begin
      if (redirect_valid) begin
        pc_q <= redirect_pc & 32'hFFFF_FFFC;
      end else if (fire) begin
        pc_q <= pc_q + 32'd4;
      end

      if (fire) begin
        af_wr_q <= ptr_inc(af_wr_q);
      end
      if (retire) begin
        af_rd_q <= ptr_inc(af_rd_q);
      end
      outstanding_q <= outstanding_q + CNT_W'(fire) - CNT_W'(retire);

      // Everything still in flight at a redirect belongs to the squashed path.
      if (redirect_valid) begin
        drop_q <= outstanding_q - CNT_W'(retire);
      end else if (retire && (drop_q != '0)) begin
        drop_q <= drop_q - CNT_W'(1);
      end

      if (redirect_valid) begin
        occ_q   <= '0;
        bf_wr_q <= '0;
        bf_rd_q <= '0;
      end else begin
        if (push) begin
          bf_wr_q <= ptr_inc(bf_wr_q);
        end
        if (pop) begin
          bf_rd_q <= ptr_inc(bf_rd_q);
        end
        occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (fire) begin
      addr_fifo[af_wr_q] <= pc_q;
    end
    if (push) begin
      buf_pc[bf_wr_q]    <= addr_fifo[af_rd_q];
      buf_instr[bf_wr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model plus a scoreboard of
// fetched PCs that decode is expected to see, with directed redirect/reset scenarios.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;

  logic        nx_reset;
  logic        nx_if_ready;
  logic        nx_req_ready;
  logic        nx_redir;
  logic [31:0] nx_redir_pc;
  logic        hold_rsp;
  logic        stale_rsp;

  mem_t        mem_q [$];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: apply queued inputs at negedge, then update the models.
  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    reset          = nx_reset;
    if_ready       = nx_if_ready;
    imem_req_ready = nx_req_ready;
    redirect_valid = nx_redir;
    redirect_pc    = nx_redir_pc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (stale_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (nx_reset && !hold_rsp && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    #1;
    if (!reset) begin
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("rst_if_valid", 32'(if_valid), 32'd0);
      check_eq("rst_if_pc", if_pc, 32'd0);
      check_eq("rst_if_pc_plus4", if_pc_plus4, 32'd0);
      check_eq("rst_if_instr", if_instr, 32'd0);
      exp_q.delete();
      mem_q.delete();
    end else if (redirect_valid) begin
      check_eq("redir_req_valid", 32'(imem_req_valid), 32'd0);
      exp_q.delete();
    end else begin
      if (if_valid && if_ready) begin
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sb_pc", if_pc, e);
          check_eq("sb_instr", if_instr, instr_of(e));
          check_eq("sb_pc_plus4", if_pc_plus4, e + 32'd4);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        check_eq("addr_align", 32'(imem_addr[1:0]), 32'd0);
        exp_q.push_back(imem_addr);
      end
    end
    if (reset && imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{addr: imem_addr, due: cyc + lat});
    end
  endtask

  task automatic wait_if_valid(input string tag);
    for (int i = 0; i < 20 && !if_valid; i++) step();
    check_eq(tag, 32'(if_valid), 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    nx_redir    = 1'b1;
    nx_redir_pc = target;
    step();
    nx_redir    = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; if_ready = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    nx_reset = 1'b0; nx_if_ready = 1'b0; nx_req_ready = 1'b1; nx_redir = 1'b0;
    nx_redir_pc = '0; hold_rsp = 1'b0; stale_rsp = 1'b0;

    repeat (3) step();

    // Release reset with decode stalled: fill latency, then buffer fills and requests stop.
    nx_reset = 1'b1;
    step();
    check_eq("first_addr", imem_addr, RESET_PC);
    check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    check_eq("fill_valid_n1", 32'(if_valid), 32'd0);
    step();
    check_eq("fill_valid_n2", 32'(if_valid), 32'd1);
    check_eq("fill_head_pc", if_pc, RESET_PC);
    repeat (3) step();
    check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("stall_head_pc", if_pc, RESET_PC);
    check_eq("stall_head_instr", if_instr, instr_of(RESET_PC));

    nx_if_ready = 1'b1;
    repeat (20) step();

    // Two requests outstanding with memory silent, then redirect.
    hold_rsp = 1'b1;
    repeat (5) step();
    check_eq("hold_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("hold_if_valid", 32'(if_valid), 32'd0);
    hold_rsp = 1'b0;
    redirect_to(32'h0000_0100);
    check_eq("redir_addr", imem_addr, 32'h0000_0100);
    wait_if_valid("redir_wait");
    check_eq("redir_head_pc", if_pc, 32'h0000_0100);
    check_eq("redir_head_instr", if_instr, instr_of(32'h0000_0100));

    // Back-to-back redirects: the later target wins.
    nx_redir = 1'b1; nx_redir_pc = 32'h0000_0300;
    step();
    nx_redir_pc = 32'h0000_0400;
    step();
    nx_redir = 1'b0;
    step();
    check_eq("b2b_addr", imem_addr, 32'h0000_0400);
    wait_if_valid("b2b_wait");
    check_eq("b2b_head_pc", if_pc, 32'h0000_0400);

    // Redirect while decode is consuming: buffer flushed, nothing popped.
    nx_if_ready = 1'b0;
    repeat (3) step();
    check_eq("pre_flush_valid", 32'(if_valid), 32'd1);
    nx_if_ready = 1'b1;
    nx_redir = 1'b1; nx_redir_pc = 32'h0000_0500;
    step();
    check_eq("flush_cycle_valid", 32'(if_valid), 32'd1);
    nx_redir = 1'b0;
    step();
    check_eq("flush_empty", 32'(if_valid), 32'd0);
    wait_if_valid("flush_wait");
    check_eq("flush_head_pc", if_pc, 32'h0000_0500);

    // Misaligned redirect target.
    redirect_to(32'h0000_0203);
    check_eq("misalign_addr", imem_addr, 32'h0000_0200);
    wait_if_valid("misalign_wait");
    check_eq("misalign_head_pc", if_pc, 32'h0000_0200);

    // PC wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    check_eq("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 20 && !(imem_req_valid && imem_req_ready); i++) step();
    check_eq("wrap_fire", 32'(imem_req_valid && imem_req_ready), 32'd1);
    step();
    check_eq("wrap_addr", imem_addr, 32'h0000_0000);
    wait_if_valid("wrap_wait");
    check_eq("wrap_head_pc", if_pc, 32'hFFFF_FFFC);
    check_eq("wrap_head_plus4", if_pc_plus4, 32'h0000_0000);

    // Random backpressure, latency and redirects.
    for (int i = 0; i < 300; i++) begin
      nx_if_ready  = ($urandom_range(0, 3) != 0);
      nx_req_ready = ($urandom_range(0, 2) != 0);
      lat          = int'($urandom_range(1, 3));
      nx_redir     = ($urandom_range(0, 24) == 0);
      nx_redir_pc  = $urandom;
      step();
    end

    // Reset mid-stream with exactly one request outstanding.
    nx_redir = 1'b0; nx_if_ready = 1'b1; nx_req_ready = 1'b0; lat = 1;
    repeat (8) step();
    nx_req_ready = 1'b1;
    step();
    check_eq("mid_fire", 32'(imem_req_valid && imem_req_ready), 32'd1);
    nx_req_ready = 1'b0;
    hold_rsp = 1'b1;
    step();
    nx_reset = 1'b0;
    stale_rsp = 1'b1;
    step();
    nx_reset = 1'b1;
    nx_req_ready = 1'b1;
    step();
    check_eq("rst_release_addr", imem_addr, RESET_PC);
    check_eq("rst_release_req", 32'(imem_req_valid), 32'd1);
    check_eq("rst_release_valid", 32'(if_valid), 32'd0);
    stale_rsp = 1'b0;
    hold_rsp = 1'b0;
    wait_if_valid("rst_wait");
    check_eq("rst_head_pc", if_pc, RESET_PC);
    check_eq("rst_head_instr", if_instr, instr_of(RESET_PC));

    // Drain: everything fetched must have reached decode.
    nx_req_ready = 1'b0;
    repeat (10) step();
    check_eq("drain_if_valid", 32'(if_valid), 32'd0);
    check_eq("drain_no_loss", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
